// File: rtl/memory_stage_pkg.sv
// ---------------------------------------------------------------------------
// memory_stage_pkg
// Shared Y86-64 constants for the memory stage: instruction codes, status
// codes, and the memory-access decode used by memory_stage.
//
// Contents:
//   I*              4-bit instruction codes (icode field)
//   S*              3-bit status codes carried down the pipeline
//   mem_access_e    kind of data-memory access an instruction performs
//   access_dec_t    decoded access kind plus address source
//   decode_access() icode -> access_dec_t
// ---------------------------------------------------------------------------
package memory_stage_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] SAOK = 3'h1;
  localparam logic [2:0] SHLT = 3'h2;
  localparam logic [2:0] SADR = 3'h3;
  localparam logic [2:0] SINS = 3'h4;

  // Width of one data-memory word in bytes
  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } mem_access_e;

  typedef struct packed {
    mem_access_e access;
    // popq/ret address the stack through valA (the old %rsp); everything
    // else uses the ALU result valE.
    logic        addr_from_vala;
  } access_dec_t;

  function automatic access_dec_t decode_access(input logic [3:0] icode);
    access_dec_t dec;
    dec.access         = ACC_NONE;
    dec.addr_from_vala = 1'b0;
    unique case (icode)
      IRMMOVQ, IPUSHQ, ICALL: dec.access = ACC_WRITE;
      IMRMOVQ:                dec.access = ACC_READ;
      IPOPQ, IRET: begin
        dec.access         = ACC_READ;
        dec.addr_from_vala = 1'b1;
      end
      default:                dec.access = ACC_NONE;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Byte-addressable data memory with 8-byte little-endian word access.
// Reads are asynchronous (combinational from the current array contents);
// writes and the reset clear happen on the rising clock edge.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset; clears every byte, and
//                 takes priority over a write on the same edge
//   addr_i   in   64-bit byte address of the word (unaligned allowed)
//   wdata_i  in   64-bit store data; bits [7:0] go to byte addr_i
//   we_i     in   write enable
//   rdata_o  out  64-bit word read from addr_i..addr_i+7
//
// The caller is responsible for rejecting addresses whose word would run
// past the end of the array; bytes outside the array read as 0 and are
// never written, so a stray address cannot corrupt or index out of range.
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        we_i,
  output logic [63:0] rdata_o
);

  localparam int          IDX_W    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] SIZE_64  = 64'(MEM_BYTES);

  logic [7:0]       mem_q [MEM_BYTES];
  logic [7:0]       mem_d [MEM_BYTES];

  logic [63:0]      byte_addr [8];
  logic             byte_ok   [8];
  logic [IDX_W-1:0] byte_idx  [8];

  // Per-byte address of the word. Each byte is range-checked on its own so
  // that addr+k is never allowed to wrap into a valid low address.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      byte_addr[k] = addr_i + 64'(k);
      byte_ok[k]   = (addr_i < SIZE_64) && (byte_addr[k] < SIZE_64);
      byte_idx[k]  = byte_addr[k][IDX_W-1:0];
    end
  end

  // Asynchronous little-endian read.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < 8; k++) begin
      if (byte_ok[k]) begin
        rdata_o[8*k +: 8] = mem_q[byte_idx[k]];
      end
    end
  end

  // Next memory contents: only the eight addressed bytes change.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_ok[k]) begin
          mem_d[byte_idx[k]] = wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// Memory (M) stage of the Y86-64 pipelined CPU. Decodes the instruction in
// M into a load, a store or no access, selects the address, checks it
// against the memory bounds, gates the write and produces the m_* signals
// for the M->W register, forwarding and pipeline control.
//
// Parameters:
//   MEM_BYTES     data memory size in bytes (must be >= 8)
//
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset (clears data memory)
//   M_stat_i      in   status of the instruction in M
//   M_icode_i     in   icode of the instruction in M
//   M_valE_i      in   ALU result; address for rmmovq/mrmovq/pushq/call
//   M_valA_i      in   store data for stores; address for popq/ret
//   m_valM_o      out  load data, 0 when no valid read happens
//   m_stat_o      out  SADR on address error, else M_stat_i
//   dmem_error_o  out  address error for the current access
// ---------------------------------------------------------------------------
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        dmem_error_o
);

  // Highest legal word start address. Comparing against this (rather than
  // computing addr+8) keeps the check correct near 2^64.
  localparam logic [63:0] LAST_WORD_ADDR = 64'(MEM_BYTES - WORD_BYTES);

  access_dec_t dec;
  logic        is_read;
  logic        is_write;
  logic [63:0] mem_addr;
  logic        addr_error;
  logic        mem_we;
  logic [63:0] mem_rdata;

  // Access decode and address select. While reset is held the stage is
  // treated as idle so its outputs match those of a bubble.
  always_comb begin
    dec      = decode_access(M_icode_i);
    is_read  = (dec.access == ACC_READ)  && !rst_i;
    is_write = (dec.access == ACC_WRITE) && !rst_i;
    mem_addr = dec.addr_from_vala ? M_valA_i : M_valE_i;
  end

  // Bounds check, unsigned 64-bit. Unaligned addresses are legal.
  always_comb begin
    addr_error = (is_read || is_write) && (mem_addr > LAST_WORD_ADDR);
  end

  // A faulting or already-excepted instruction must never modify memory.
  always_comb begin
    mem_we = is_write && !addr_error && (M_stat_i == SAOK) && !rst_i;
  end

  data_memory #(
    .MEM_BYTES (MEM_BYTES)
  ) u_data_memory (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (mem_addr),
    .wdata_i (M_valA_i),
    .we_i    (mem_we),
    .rdata_o (mem_rdata)
  );

  // Output muxing: load data only for an in-range read; status overridden
  // by SADR on an address error and passed through otherwise.
  always_comb begin
    m_valM_o     = (is_read && !addr_error) ? mem_rdata : 64'd0;
    dmem_error_o = addr_error;
    m_stat_o     = addr_error ? SADR : M_stat_i;
  end

endmodule
